// File: rtl/add_sequencer.sv
// Multi-word adder that reuses one 16-bit lookahead slice for NWORDS cycles, lowest slice first.
// Optional subtract mode is enabled by defining ADD_SEQUENCER_SUB_EN.
module add_sequencer #(
    parameter int NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [16*NWORDS-1:0] a,
    input  logic [16*NWORDS-1:0] b,
    input  logic                 cin,
`ifdef ADD_SEQUENCER_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [16*NWORDS-1:0] sum,
    output logic                 cout,
    output logic                 overflow
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one slice added per cycle, idx selects the slice
    // DONE  | result valid for this cycle; a new start may be accepted
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [16*NWORDS-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                   carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [15:0]            a_sl, b_sl;
    logic [17:0]            res;
    logic                   last;
    logic [16*NWORDS-1:0]   b_eff;
    logic                   c_init;

    // Returns {carry into bit 15, carry out of bit 15, 16-bit sum}.
    function automatic logic [17:0] slice_add(input logic [15:0] x, input logic [15:0] y,
                                              input logic ci);
        logic [15:0] p, g, s;
        logic [16:0] c;
        logic [4:0]  cg;
        logic        gg, pg;
        p  = x | y;
        g  = x & y;
        c  = '0;
        cg = '0;
        cg[0] = ci;
        for (int k = 0; k < 4; k++) begin
            gg = 1'b0;
            pg = 1'b1;
            for (int j = 0; j < 4; j++) begin
                gg = g[4*k+j] | (p[4*k+j] & gg);
                pg = pg & p[4*k+j];
            end
            cg[k+1] = gg | (pg & cg[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = cg[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[16] = cg[4];
        s = x ^ y ^ c[15:0];
        return {c[15], c[16], s};
    endfunction

`ifdef ADD_SEQUENCER_SUB_EN
    // Subtract is a + ~b + 1, so the latched b is already inverted.
    assign b_eff  = sub ? ~b : b;
    assign c_init = sub ? 1'b1 : cin;
`else
    assign b_eff  = b;
    assign c_init = cin;
`endif

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx_q == 3'(i)) begin
                a_sl = a_q[16*i +: 16];
                b_sl = b_q[16*i +: 16];
            end
        end
        res  = slice_add(a_sl, b_sl, carry_q);
        last = (idx_q == 3'(NWORDS-1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                for (int i = 0; i < NWORDS; i++) begin
                    if (idx_q == 3'(i)) sum_d[16*i +: 16] = res[15:0];
                end
                carry_d = res[16];
                idx_d   = idx_q + 3'd1;
                if (last) begin
                    cout_d  = res[16];
                    ovf_d   = res[17] ^ res[16];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (start && (state_q != RUN)) begin
            idx_d   = '0;
            a_d     = a;
            b_d     = b_eff;
            carry_d = c_init;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
